pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

- Holds the architectural fetch PC and drives it to the 32-bit PC incrementer; consumes the incrementer's sum as the sequential next PC.
- Issues instruction-fetch requests to instruction memory over a req/addr_ok handshake.
- Applies branch and exception redirects without ever changing an address that is still awaiting acceptance.
- Sits between the incrementer/redirect logic and the IF/ID boundary.

## Interface
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- pc_plus4  in  32  incrementer result (pc + 4), combinational from `pc`.
- stall  in  1  pipeline back-pressure: no new request may start.
- br_taken  in  1  branch/jump redirect strobe.
- br_target  in  32  branch/jump target.
- exc_taken  in  1  exception/ERET redirect strobe.
- exc_target  in  32  exception vector / EPC.
- inst_addr_ok  in  1  memory accepts the current request.
- pc  out  32  current fetch address; also the incrementer operand.
- inst_req  out  1  request valid.
- issue_fire  out  1  inst_req & inst_addr_ok (combinational).
- issue_kill  out  1  request accepted this cycle must be discarded downstream.
- pc_adel  out  1  misaligned-fetch flag (see Configuration).

## Operation
- States:
  - RST: entered on reset; inst_req=0.
  - REQ: inst_req=1.
  - HOLD: stalled; inst_req=0.
  - ADEL: misaligned PC; inst_req=0, pc_adel=1.
- RST → REQ on the first clock after reset deasserts, or → HOLD if stall=1.
- REQ transitions:
  - On fire: pc ← next address.
  - After fire: → HOLD if stall=1, else stay in REQ.
  - Without fire: stay in REQ, holding pc and inst_req even if stall rises. Stall never withdraws an issued request.
- HOLD → REQ when stall=0.
- Next address after a fire, in priority order: pending redirect, then a redirect sampled this cycle, then pc_plus4.
- Redirect priority: exc_taken > br_taken.
- Redirect sampled in REQ without fire:
  - Latch target into the pending register; pc is unchanged.
  - At the later fire: issue_kill=1, pc ← pending target, pending cleared.
- Redirect sampled in REQ with fire: issue_kill=1 that cycle; pc ← target.
- Redirect sampled in RST/HOLD/ADEL: pc ← target next edge; no kill. Leave ADEL only through exc_taken; go → REQ (or HOLD if stall=1).
- Pending-register overwrite rules:
  - A new exception overwrites a pending branch or exception.
  - A branch never overwrites a pending exception.
  - A branch overwrites a pending branch.
- Arithmetic: no internal adder. pc_plus4 wraps modulo 2^32, so 32'hFFFF_FFFC → 0.

## Timing
- Reset values: pc=RESET_PC, inst_req=0, issue_kill=0, pc_adel=0, pending cleared, state RST.
- Asserting rst mid-request forces these values immediately. An in-flight handshake is abandoned.
- Request latency: inst_req rises 1 cycle after reset release.
- Back-to-back fires are possible: 1 address per cycle when inst_addr_ok is held high.
- pc and inst_req change only at clock edges. Both are stable while inst_req=1 and inst_addr_ok=0.
- Redirect-to-new-address latency:
  - 1 cycle when not in REQ, or when fire coincides with the redirect.
  - Otherwise 1 cycle after the pending request fires.
- Redirect strobes are single-cycle. Holding one high re-samples it every cycle and obeys the same rules.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - Any pc with pc[1:0]≠0 entering REQ or HOLD goes to ADEL instead; no request is issued.
  - pc_adel=1 while in ADEL.
- PC_ALIGN_CHECK_EN undefined:
  - pc_adel is tied to 0 and the ADEL state is absent.
  - Misaligned pc is issued unchanged.

## Test plan
- Reset with RESET_PC default, addr_ok=1 → inst_req=0 first cycle, then addresses BFC00000, BFC00004, BFC00008 on consecutive cycles; issue_kill=0.
- Set addr_ok=0 for 3 cycles while stall=1 → pc and inst_req hold at the same value. After fire: HOLD (inst_req=0) until stall drops.
- In REQ with addr_ok=0, pulse br_taken with target 00400100. Two cycles later assert addr_ok → that fire has issue_kill=1, next pc=00400100.
- exc_taken (80000180) and br_taken (00400200) in the same cycle with fire → issue_kill=1, pc=80000180.
- Pending exception 80000180, then br_taken 00400300 before the fire → pc=80000180 after the fire.
- With PC_ALIGN_CHECK_EN: br_target 00400102 → pc_adel=1, no inst_req. Then exc_taken 80000180 → REQ at 80000180, pc_adel=0.
- rst asserted mid-REQ → pc=BFC00000 and inst_req=0 immediately.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//
// Holds the architectural fetch PC, issues instruction-fetch requests over a
// req/addr_ok handshake, and applies branch/exception redirects without ever
// disturbing an address that is still waiting to be accepted.
//
// Parameters:
//   RESET_PC      PC value loaded on reset.
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous, active-high reset
//   pc_plus4      external incrementer result (pc + 4, wraps mod 2^32)
//   stall         back-pressure: no new request may start
//   br_taken      branch/jump redirect strobe
//   br_target     branch/jump target
//   exc_taken     exception/ERET redirect strobe (wins over br_taken)
//   exc_target    exception vector / EPC
//   inst_addr_ok  memory accepts the current request
//   pc            current fetch address (also the incrementer operand)
//   inst_req      request valid (registered)
//   issue_fire    inst_req & inst_addr_ok
//   issue_kill    the request accepted this cycle is stale and must be dropped
//   pc_adel       misaligned-fetch flag
//
// Build option:
//   PC_ALIGN_CHECK_EN  when defined, a misaligned pc parks the fetcher in an
//                      address-error state (pc_adel=1, no request) until an
//                      exception redirect arrives. When undefined, pc_adel is
//                      tied low and misaligned addresses are issued unchanged.

module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_taken,
    input  logic [31:0] exc_target,
    input  logic        inst_addr_ok,
    output logic [31:0] pc,
    output logic        inst_req,
    output logic        issue_fire,
    output logic        issue_kill,
    output logic        pc_adel
);

`ifdef PC_ALIGN_CHECK_EN
    typedef enum logic [1:0] {ST_RST, ST_REQ, ST_HOLD, ST_ADEL} state_t;
`else
    typedef enum logic [1:0] {ST_RST, ST_REQ, ST_HOLD} state_t;
`endif

    state_t      state, nxt_state;
    logic [31:0] nxt_pc;
    logic        pend_valid, nxt_pend_valid;
    logic        pend_exc, nxt_pend_exc;
    logic [31:0] pend_tgt, nxt_pend_tgt;
    logic        redir;
    logic [31:0] redir_tgt;
    logic        enter;

    assign redir      = exc_taken | br_taken;
    assign redir_tgt  = exc_taken ? exc_target : br_target;
    assign issue_fire = inst_req & inst_addr_ok;
    // A fire is stale if a redirect is waiting or arrives in the same cycle.
    assign issue_kill = issue_fire & (pend_valid | redir);

    always_comb begin
        nxt_state      = state;
        nxt_pc         = pc;
        nxt_pend_valid = pend_valid;
        nxt_pend_exc   = pend_exc;
        nxt_pend_tgt   = pend_tgt;
        enter          = 1'b0;

        case (state)
            ST_REQ: begin
                if (issue_fire) begin
                    enter = 1'b1;
                    if (pend_valid)
                        nxt_pc = pend_tgt;
                    else if (redir)
                        nxt_pc = redir_tgt;
                    else
                        nxt_pc = pc_plus4;
                    nxt_pend_valid = 1'b0;
                    nxt_pend_exc   = 1'b0;
                end else if (exc_taken) begin
                    // The outstanding address must not move; park the redirect.
                    nxt_pend_valid = 1'b1;
                    nxt_pend_exc   = 1'b1;
                    nxt_pend_tgt   = exc_target;
                end else if (br_taken && !(pend_valid && pend_exc)) begin
                    nxt_pend_valid = 1'b1;
                    nxt_pend_exc   = 1'b0;
                    nxt_pend_tgt   = br_target;
                end
            end
`ifdef PC_ALIGN_CHECK_EN
            ST_ADEL: begin
                // Only an exception redirect leaves the address-error state.
                if (exc_taken) begin
                    enter  = 1'b1;
                    nxt_pc = exc_target;
                end else if (br_taken) begin
                    nxt_pc = br_target;
                end
            end
`endif
            default: begin
                enter = 1'b1;
                if (redir)
                    nxt_pc = redir_tgt;
            end
        endcase

        if (enter) begin
            nxt_state = stall ? ST_HOLD : ST_REQ;
`ifdef PC_ALIGN_CHECK_EN
            if (nxt_pc[1:0] != 2'b00)
                nxt_state = ST_ADEL;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RST;
            pc         <= RESET_PC;
            inst_req   <= 1'b0;
            pend_valid <= 1'b0;
            pend_exc   <= 1'b0;
            pend_tgt   <= '0;
        end else begin
            state      <= nxt_state;
            pc         <= nxt_pc;
            inst_req   <= (nxt_state == ST_REQ);
            pend_valid <= nxt_pend_valid;
            pend_exc   <= nxt_pend_exc;
            pend_tgt   <= nxt_pend_tgt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic adel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            adel_q <= 1'b0;
        else
            adel_q <= (nxt_state == ST_ADEL);
    end

    assign pc_adel = adel_q;
`else
    assign pc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_taken;
    logic [31:0] exc_target;
    logic        inst_addr_ok;
    logic [31:0] pc;
    logic        inst_req;
    logic        issue_fire;
    logic        issue_kill;
    logic        pc_adel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural PC, whether a request is outstanding,
    // whether fetch is parked on an address error, and the deferred redirect.
    logic [31:0] m_pc;
    logic [31:0] m_pend_tgt;
    bit          m_req;
    bit          m_adel;
    bit          m_pend;
    bit          m_pend_exc;
    bit          e_fire;
    bit          e_kill;

    always #5 clk = ~clk;

    // External incrementer.
    assign pc_plus4 = pc + 32'd4;

    pc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_plus4     (pc_plus4),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .exc_taken    (exc_taken),
        .exc_target   (exc_target),
        .inst_addr_ok (inst_addr_ok),
        .pc           (pc),
        .inst_req     (inst_req),
        .issue_fire   (issue_fire),
        .issue_kill   (issue_kill),
        .pc_adel      (pc_adel)
    );

    task automatic model_reset();
        m_pc       = RESET_PC;
        m_pend_tgt = '0;
        m_req      = 0;
        m_adel     = 0;
        m_pend     = 0;
        m_pend_exc = 0;
    endtask

    // Arrival at a new address: parked on misalignment, otherwise request
    // unless stalled.
    task automatic settle();
        m_adel = ALIGN && (m_pc[1:0] != 2'b00);
        m_req  = !m_adel && !stall;
    endtask

    // Apply inputs just after a falling edge and form the expected
    // combinational outputs.
    task automatic drive(input bit s, input bit ok, input bit b, input logic [31:0] bt,
                         input bit e, input logic [31:0] et);
        stall        = s;
        inst_addr_ok = ok;
        br_taken     = b;
        br_target    = bt;
        exc_taken    = e;
        exc_target   = et;
        #1;
        e_fire = m_req && ok;
        e_kill = e_fire && (m_pend || b || e);
    endtask

    // Advance the model across the rising edge, then move to the next falling edge.
    task automatic advance();
        bit          redir;
        logic [31:0] tgt;
        redir = br_taken || exc_taken;
        tgt   = exc_taken ? exc_target : br_target;
        if (m_req) begin
            if (inst_addr_ok) begin
                if (m_pend)      m_pc = m_pend_tgt;
                else if (redir)  m_pc = tgt;
                else             m_pc = m_pc + 32'd4;
                m_pend = 0;
                settle();
            end else if (exc_taken) begin
                m_pend = 1; m_pend_exc = 1; m_pend_tgt = exc_target;
            end else if (br_taken && !(m_pend && m_pend_exc)) begin
                m_pend = 1; m_pend_exc = 0; m_pend_tgt = br_target;
            end
        end else if (m_adel) begin
            if (exc_taken) begin
                m_pc = exc_target;
                settle();
            end else if (br_taken) begin
                m_pc = br_target;
            end
        end else begin
            if (redir) m_pc = tgt;
            settle();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({pc, inst_req, issue_kill, pc_adel} !== {RESET_PC, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h req=%b kill=%b adel=%b, expected pc=%h req=0 kill=0 adel=0",
                     pc, inst_req, issue_kill, pc_adel, RESET_PC);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(0, 1, 0, '0, 0, '0);
        n_checks++;
        if (inst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL first_cycle_req: got %b expected 0", inst_req);
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, '0, 0, '0);
            n_checks++;
            if ({pc, inst_req, issue_fire, issue_kill} !== {RESET_PC + 32'(4 * i), 3'b110}) begin
                n_fail++;
                $display("FAIL seq_fetch[%0d]: got pc=%h req=%b fire=%b kill=%b expected pc=%h req=1 fire=1 kill=0",
                         i, pc, inst_req, issue_fire, issue_kill, RESET_PC + 32'(4 * i));
            end
            advance();
        end
    endtask

    task automatic test_stall_hold();
        logic [31:0] held;
        held = m_pc;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, '0, 0, '0);
            n_checks++;
            if ({pc, inst_req, issue_fire} !== {held, 2'b10}) begin
                n_fail++;
                $display("FAIL stall_no_withdraw[%0d]: got pc=%h req=%b fire=%b expected pc=%h req=1 fire=0",
                         i, pc, inst_req, issue_fire, held);
            end
            advance();
        end
        drive(1, 1, 0, '0, 0, '0);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, '0, 0, '0);
            n_checks++;
            if ({pc, inst_req, issue_fire} !== {held + 32'd4, 2'b00}) begin
                n_fail++;
                $display("FAIL hold_state[%0d]: got pc=%h req=%b fire=%b expected pc=%h req=0 fire=0",
                         i, pc, inst_req, issue_fire, held + 32'd4);
            end
            advance();
        end
        drive(0, 0, 0, '0, 0, '0);
        advance();
        drive(0, 0, 0, '0, 0, '0);
        n_checks++;
        if ({pc, inst_req} !== {held + 32'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_release: got pc=%h req=%b expected pc=%h req=1", pc, inst_req, held + 32'd4);
        end
        advance();
    endtask

    task automatic test_pending_branch();
        logic [31:0] held;
        held = m_pc;
        drive(0, 0, 1, 32'h0040_0100, 0, '0);
        advance();
        drive(0, 0, 0, '0, 0, '0);
        n_checks++;
        if ({pc, inst_req} !== {held, 1'b1}) begin
            n_fail++;
            $display("FAIL pend_br_pc_stable: got pc=%h req=%b expected pc=%h req=1", pc, inst_req, held);
        end
        advance();
        drive(0, 1, 0, '0, 0, '0);
        n_checks++;
        if ({issue_fire, issue_kill} !== 2'b11) begin
            n_fail++;
            $display("FAIL pend_br_kill: got fire=%b kill=%b expected fire=1 kill=1", issue_fire, issue_kill);
        end
        advance();
        drive(0, 1, 0, '0, 0, '0);
        n_checks++;
        if ({pc, issue_kill} !== {32'h0040_0100, 1'b0}) begin
            n_fail++;
            $display("FAIL pend_br_target: got pc=%h kill=%b expected pc=00400100 kill=0", pc, issue_kill);
        end
        advance();
    endtask

    task automatic test_exc_over_br();
        drive(0, 1, 1, 32'h0040_0200, 1, 32'h8000_0180);
        n_checks++;
        if ({issue_fire, issue_kill} !== 2'b11) begin
            n_fail++;
            $display("FAIL same_cycle_kill: got fire=%b kill=%b expected fire=1 kill=1", issue_fire, issue_kill);
        end
        advance();
        drive(0, 1, 0, '0, 0, '0);
        n_checks++;
        if (pc !== 32'h8000_0180) begin
            n_fail++;
            $display("FAIL exc_priority: got pc=%h expected 80000180", pc);
        end
        advance();
    endtask

    task automatic test_pending_exc_blocks_br();
        drive(0, 0, 0, '0, 1, 32'h8000_0180);
        advance();
        drive(0, 0, 1, 32'h0040_0300, 0, '0);
        advance();
        drive(0, 1, 0, '0, 0, '0);
        n_checks++;
        if (issue_kill !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_exc_kill: got kill=%b expected 1", issue_kill);
        end
        advance();
        drive(0, 1, 0, '0, 0, '0);
        n_checks++;
        if (pc !== 32'h8000_0180) begin
            n_fail++;
            $display("FAIL pend_exc_kept: got pc=%h expected 80000180", pc);
        end
        advance();
    endtask

    task automatic test_back_to_back_wrap();
        drive(0, 1, 1, 32'hFFFF_FFF8, 0, '0);
        advance();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] want;
            want = 32'hFFFF_FFF8 + 32'(4 * i);
            drive(0, 1, 0, '0, 0, '0);
            n_checks++;
            if ({pc, issue_fire, issue_kill} !== {want, 2'b10}) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got pc=%h fire=%b kill=%b expected pc=%h fire=1 kill=0",
                         i, pc, issue_fire, issue_kill, want);
            end
            advance();
        end
    endtask

    task automatic test_misaligned();
        drive(0, 1, 1, 32'h0040_0102, 0, '0);
        advance();
        drive(0, 1, 0, '0, 0, '0);
        n_checks++;
        if ({pc, inst_req, issue_fire, pc_adel} !== {32'h0040_0102, !ALIGN, !ALIGN, ALIGN}) begin
            n_fail++;
            $display("FAIL misaligned: got pc=%h req=%b fire=%b adel=%b expected pc=00400102 req=%b fire=%b adel=%b",
                     pc, inst_req, issue_fire, pc_adel, !ALIGN, !ALIGN, ALIGN);
        end
        advance();
        drive(0, 1, 0, '0, 1, 32'h8000_0180);
        advance();
        drive(0, 1, 0, '0, 0, '0);
        n_checks++;
        if ({pc, inst_req, pc_adel} !== {32'h8000_0180, 2'b10}) begin
            n_fail++;
            $display("FAIL adel_exit: got pc=%h req=%b adel=%b expected pc=80000180 req=1 adel=0",
                     pc, inst_req, pc_adel);
        end
        advance();
    endtask

    task automatic test_rst_mid_req();
        drive(0, 1, 0, '0, 0, '0);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({pc, inst_req, issue_fire, issue_kill} !== {RESET_PC, 3'b000}) begin
            n_fail++;
            $display("FAIL rst_async: got pc=%h req=%b fire=%b kill=%b expected pc=%h req=0 fire=0 kill=0",
                     pc, inst_req, issue_fire, issue_kill, RESET_PC);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 0, '0, 0, '0);
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit          s, ok, b, e;
            logic [31:0] bt, et;
            s  = ($urandom_range(0, 9) < 3);
            ok = ($urandom_range(0, 1) == 1);
            b  = ($urandom_range(0, 99) < 15);
            e  = ($urandom_range(0, 99) < 10);
            bt = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            et = $urandom & 32'hFFFF_FFFC;
            drive(s, ok, b, bt, e, et);
            n_checks++;
            if ({pc, inst_req, issue_fire, issue_kill, pc_adel} !== {m_pc, m_req, e_fire, e_kill, m_adel}) begin
                n_fail++;
                $display("FAIL random[%0d]: got pc=%h req=%b fire=%b kill=%b adel=%b expected pc=%h req=%b fire=%b kill=%b adel=%b",
                         i, pc, inst_req, issue_fire, issue_kill, pc_adel,
                         m_pc, m_req, e_fire, e_kill, m_adel);
            end
            advance();
        end
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        br_taken     = 1'b0;
        br_target    = '0;
        exc_taken    = 1'b0;
        exc_target   = '0;
        inst_addr_ok = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_stall_hold();
        test_pending_branch();
        test_exc_over_br();
        test_pending_exc_blocks_br();
        test_back_to_back_wrap();
        test_misaligned();
        test_rst_mid_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
